// File: rtl/fetch_pkg.sv
// Shared encodings for the instruction fetch unit: FSM states and branch condition codes.
// Pure type/constant package, no logic.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_VALID = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_e;

  typedef enum logic [1:0] {
    BR_NONE   = 2'b00,
    BR_ZERO   = 2'b01,
    BR_NZERO  = 2'b10,
    BR_ALWAYS = 2'b11
  } br_type_e;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC arithmetic: sequential, PC-relative branch and region-absolute jump targets with priority.
// Purely combinational, zero latency; no flow control.
module pc_next_calc
  import fetch_pkg::*;
#(
  parameter int PC_W  = 30,
  parameter int IMM_W = 16,
  parameter int JT_W  = 26
) (
  input  logic [PC_W-1:0]  pc_i,
  input  logic [1:0]       br_type_i,
  input  logic             zero_i,
  input  logic [IMM_W-1:0] imm_i,
  input  logic             jump_i,
  input  logic [JT_W-1:0]  jump_target_i,
  output logic [PC_W-1:0]  next_pc_o
);

  logic [PC_W-1:0] seq;
  logic [PC_W-1:0] imm_sext;
  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] jmp_tgt;
  logic            br_taken;
  br_type_e        br_kind;

  // Addition naturally wraps modulo 2^PC_W, so all-ones rolls over to zero.
  assign seq = pc_i + {{(PC_W-1){1'b0}}, 1'b1};

  // Bit-wise construction stays legal even when IMM_W or JT_W equals PC_W.
  for (genvar i = 0; i < PC_W; i++) begin : g_ext
    if (i < IMM_W) begin : g_imm_lo
      assign imm_sext[i] = imm_i[i];
    end else begin : g_imm_hi
      assign imm_sext[i] = imm_i[IMM_W-1];
    end
    if (i < JT_W) begin : g_jt_lo
      assign jmp_tgt[i] = jump_target_i[i];
    end else begin : g_jt_hi
      assign jmp_tgt[i] = seq[i];
    end
  end

  assign br_tgt  = seq + imm_sext;
  assign br_kind = br_type_e'(br_type_i);

  always_comb begin
    br_taken = 1'b0;
    unique case (br_kind)
      BR_NONE:   br_taken = 1'b0;
      BR_ZERO:   br_taken = zero_i;
      BR_NZERO:  br_taken = ~zero_i;
      BR_ALWAYS: br_taken = 1'b1;
      default:   br_taken = 1'b0;
    endcase
  end

  always_comb begin
    next_pc_o = seq;
    if (jump_i) begin
      next_pc_o = jmp_tgt;
    end else if (br_taken) begin
      next_pc_o = br_tgt;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Single-outstanding instruction fetch FSM; request to valid is gnt + rvalid + 1 cycle.
// Holds instr stable while instr_ready is low; a bus error halts fetching until reset.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 30,
  parameter int              IMM_W    = 16,
  parameter int              JT_W     = 26,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_err,
  output logic [31:0]      instr,
  output logic [PC_W-1:0]  instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic [1:0]       br_type,
  input  logic             zero,
  input  logic [IMM_W-1:0] imm,
  input  logic             jump,
  input  logic [JT_W-1:0]  jump_target,
  output logic             fault
);

  fetch_state_e    state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [31:0]     instr_q;
  logic [PC_W-1:0] instr_pc_q;
  logic            instr_valid_q;
  logic            imem_req_q;
  logic            fault_q;

  // Branch inputs only matter on the retiring VALID cycle; the FSM gates the load.
  pc_next_calc #(
    .PC_W  (PC_W),
    .IMM_W (IMM_W),
    .JT_W  (JT_W)
  ) u_pc_next_calc (
    .pc_i          (instr_pc_q),
    .br_type_i     (br_type),
    .zero_i        (zero),
    .imm_i         (imm),
    .jump_i        (jump),
    .jump_target_i (jump_target),
    .next_pc_o     (pc_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          imem_req_q <= 1'b1;
          state_q    <= ST_REQ;
        end
        ST_REQ: begin
          // rvalid in the grant cycle is deliberately ignored; memory holds it into WAIT.
          if (imem_gnt) begin
            imem_req_q <= 1'b0;
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (imem_err) begin
              fault_q <= 1'b1;
              state_q <= ST_HALT;
            end else begin
              instr_q       <= imem_rdata;
              instr_pc_q    <= pc_q;
              instr_valid_q <= 1'b1;
              state_q       <= ST_VALID;
            end
          end
        end
        ST_VALID: begin
          if (instr_ready) begin
            pc_q          <= pc_d;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b1;
            state_q       <= ST_REQ;
          end
        end
        ST_HALT: begin
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
          fault_q       <= 1'b1;
        end
        default: begin
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
          state_q       <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign fault       = fault_q;

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 30, meaning word-address PC width.
REQ-002 SHALL have parameter IMM_W, default 16, meaning branch offset width (IMM_W <= PC_W).
REQ-003 SHALL have parameter JT_W, default 26, meaning jump target field width (JT_W <= PC_W).
REQ-004 SHALL have parameter RESET_PC, default 0, meaning first fetch address.
REQ-005 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port imem_req  out  1  fetch request.
REQ-008 SHALL have port imem_addr  out  PC_W  fetch word address.
REQ-009 SHALL have port imem_gnt  in  1  request accepted.
REQ-010 SHALL have port imem_rvalid  in  1  read data returned.
REQ-011 SHALL have port imem_rdata  in  32  instruction word.
REQ-012 SHALL have port imem_err  in  1  bus error, qualified by imem_rvalid.
REQ-013 SHALL have port instr  out  32  held instruction.
REQ-014 SHALL have port instr_pc  out  PC_W  address of instr.
REQ-015 SHALL have port instr_valid  out  1  instr/instr_pc valid.
REQ-016 SHALL have port instr_ready  in  1  downstream accepts instr this cycle.
REQ-017 SHALL have port br_type  in  2  00 none, 01 taken-if-zero, 10 taken-if-not-zero, 11 always.
REQ-018 SHALL have port zero  in  1  ALU zero flag for the current instruction.
REQ-019 SHALL have port imm  in  IMM_W  signed word branch offset.
REQ-020 SHALL have port jump  in  1  absolute jump.
REQ-021 SHALL have port jump_target  in  JT_W  jump target field.
REQ-022 SHALL have port fault  out  1  sticky fetch error.

Function
REQ-023 SHALL run FSM states IDLE, REQ, WAIT, VALID, HALT.
REQ-024 SHALL go IDLE->REQ unconditionally, one cycle after reset release.
REQ-025 SHALL in REQ drive imem_req=1 with imem_addr=pc held stable until imem_gnt, then go to WAIT.
REQ-026 SHALL in WAIT, on imem_rvalid with imem_err=0, capture imem_rdata into instr and pc into instr_pc, then go to VALID.
REQ-027 SHALL in WAIT, on imem_rvalid with imem_err=1, go to HALT and set fault=1.
REQ-028 SHALL ignore imem_rvalid outside WAIT.
REQ-029 SHALL hold instr_valid=1 only in VALID, keeping instr and instr_pc stable while instr_ready=0.
REQ-030 SHALL sample br_type, zero, imm, jump and jump_target only in a VALID cycle with instr_ready=1; on that cycle it loads the next pc and goes to REQ.
REQ-031 SHALL compute seq = instr_pc+1 modulo 2^PC_W, so all-ones wraps to 0.
REQ-032 SHALL compute branch target = seq + sign-extended imm, modulo 2^PC_W.
REQ-033 SHALL compute jump target = {seq[PC_W-1:JT_W], jump_target}.
REQ-034 SHALL give next-pc priority: jump, then taken branch, then seq.
REQ-035 SHALL in HALT keep imem_req=0, instr_valid=0 and fault=1 until reset.
REQ-036 SHALL drive imem_req=0 in every state except REQ.
REQ-037 SHALL allow at most one outstanding fetch.
REQ-038 SHALL allow imem_gnt and imem_rvalid in the same cycle; the response is then taken the following cycle in WAIT, and same-cycle data is not lost only if the memory holds rvalid (memory contract: rvalid at least one cycle after gnt).

Reset
REQ-039 SHALL on reset_n=0 immediately force: state=IDLE, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, imem_req=0, fault=0.
REQ-040 SHALL on reset mid-fetch abandon the outstanding fetch; a later rvalid is ignored per REQ-028.

Structure
REQ-041 SHALL place the FSM state encoding and br_type encodings in shared package fetch_pkg.
REQ-042 SHALL implement next-pc arithmetic (seq, sign extension, branch and jump targets, priority) as one combinational sub-module pc_next_calc; the FSM and registers stay in pc_fetch_unit.

Verification
REQ-043 SHALL verify: reset release, gnt=1 immediately, rvalid next cycle with rdata=32'h2002_0005 -> imem_addr=0; instr_valid with instr=32'h2002_0005 and instr_pc=0; next fetch address 1.
REQ-044 SHALL verify: at instr_pc=30'h10, br_type=01, zero=1, imm=16'hFFFE -> next imem_addr=30'h0F; same with zero=0 -> 30'h11.
REQ-045 SHALL verify: at instr_pc=30'h3FFF_FFFF, br_type=00 -> next imem_addr=0 (wrap).
REQ-046 SHALL verify: jump=1 together with br_type=11, jump_target=26'h000_0040 at instr_pc=30'h0400_0000 -> next imem_addr=30'h0400_0040 (jump wins).
REQ-047 SHALL verify: instr_ready=0 for 5 cycles in VALID -> instr, instr_pc and instr_valid stable and imem_req=0 throughout.
REQ-048 SHALL verify: rvalid with imem_err=1 -> fault=1 and no further imem_req; reset_n pulse low mid-WAIT -> outputs at reset values asynchronously, refetch from RESET_PC.
